// File: rtl/tmr_rx_pkg.sv
// Shared types and helpers for the triplicated serial-to-parallel receiver.
// State encoding, the 2-of-3 majority primitive and the error counter width.
package tmr_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } rx_state_t;

  localparam int ERR_CNT_W = 8;

  // Single-bit 2-of-3 majority; callers apply it bit by bit, so it works for any width.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sipo_rx_copy.sv
// One non-redundant receiver copy: FSM, bit counter and shift register.
// When 'correct' is high the copy reloads the supplied (voted) state
// instead of advancing, which is how the top scrubs a disagreeing copy.
module sipo_rx_copy
  import tmr_rx_pkg::*;
#(
  parameter int width     = 4,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW       = $clog2(width)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             serial_in,
  input  logic             out_ready,
  input  logic             correct,
  input  rx_state_t        correct_state,
  input  logic [CW-1:0]    correct_count,
  input  logic [width-1:0] correct_data,
  output rx_state_t        state_o,
  output logic [CW-1:0]    count_o,
  output logic [width-1:0] data_o
);

  localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

  rx_state_t          state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [width-1:0]   data_q, data_d;
  logic [width-1:0]   shifted;

  // Word with serial_in shifted in, in the configured bit order.
  always_comb begin
    if (MSB_FIRST) shifted = {data_q[width-2:0], serial_in};
    else           shifted = {serial_in, data_q[width-1:1]};
  end

  // Next-state logic: scrub has priority, otherwise the normal frame FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    if (correct) begin
      state_d = correct_state;
      count_d = correct_count;
      data_d  = correct_data;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable && start) begin
            data_d  = shifted;
            count_d = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (enable) begin
            data_d = shifted;
            if (count_q == LAST_BIT) begin
              count_d = '0;
              state_d = HOLD;
            end else begin
              count_d = count_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready && enable && start) begin
            data_d  = shifted;
            count_d = CW'(1);
            state_d = SHIFT;
          end else if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          // Unused encoding (only reachable through multiple upsets): recover to IDLE.
          count_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counter and data registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the data register is reset too, so a discarded frame can never leak onto parallel_out.
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so all registers update from pre-edge values.
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign state_o = state_q;
  assign count_o = count_q;
  assign data_o  = data_q;

endmodule

// File: rtl/tmr_sipo_receiver.sv
// Triplicated serial-to-parallel receiver with valid/ready output.
// Three sipo_rx_copy instances are majority-voted bit by bit; outputs come
// from the vote and any copy that disagrees is reloaded with the vote.
// Optional feature: define TMR_SIPO_ERR_CNT_EN to add the saturating
// err_count output counting cycles on which a disagreement was seen.
module tmr_sipo_receiver
  import tmr_rx_pkg::*;
#(
  parameter int width     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             serial_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [width-1:0] parallel_out,
  output logic             busy,
  output logic             mismatch
`ifdef TMR_SIPO_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam int CW = $clog2(width);

  rx_state_t        cp_state [3];
  logic [CW-1:0]    cp_count [3];
  logic [width-1:0] cp_data  [3];

  logic [1:0]       vote_state_bits;
  rx_state_t        vote_state;
  logic [CW-1:0]    vote_count;
  logic [width-1:0] vote_data;
  logic [2:0]       disagree;
  logic             mismatch_q;

  sipo_rx_copy #(.width(width), .MSB_FIRST(MSB_FIRST)) u_copy0 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .serial_in(serial_in),
    .out_ready(out_ready), .correct(disagree[0]), .correct_state(vote_state),
    .correct_count(vote_count), .correct_data(vote_data),
    .state_o(cp_state[0]), .count_o(cp_count[0]), .data_o(cp_data[0])
  );

  sipo_rx_copy #(.width(width), .MSB_FIRST(MSB_FIRST)) u_copy1 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .serial_in(serial_in),
    .out_ready(out_ready), .correct(disagree[1]), .correct_state(vote_state),
    .correct_count(vote_count), .correct_data(vote_data),
    .state_o(cp_state[1]), .count_o(cp_count[1]), .data_o(cp_data[1])
  );

  sipo_rx_copy #(.width(width), .MSB_FIRST(MSB_FIRST)) u_copy2 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .serial_in(serial_in),
    .out_ready(out_ready), .correct(disagree[2]), .correct_state(vote_state),
    .correct_count(vote_count), .correct_data(vote_data),
    .state_o(cp_state[2]), .count_o(cp_count[2]), .data_o(cp_data[2])
  );

  // Bitwise 2-of-3 vote over state encoding, counter and data.
  always_comb begin
    vote_state_bits = '0;
    vote_count      = '0;
    vote_data       = '0;
    for (int b = 0; b < 2; b++)
      vote_state_bits[b] = maj3(cp_state[0][b], cp_state[1][b], cp_state[2][b]);
    for (int b = 0; b < CW; b++)
      vote_count[b] = maj3(cp_count[0][b], cp_count[1][b], cp_count[2][b]);
    for (int b = 0; b < width; b++)
      vote_data[b] = maj3(cp_data[0][b], cp_data[1][b], cp_data[2][b]);
  end

  assign vote_state = rx_state_t'(vote_state_bits);

  // Flag each copy whose full state differs from the vote; it is reloaded next clock.
  always_comb begin
    disagree = '0;
    for (int i = 0; i < 3; i++)
      disagree[i] = (cp_state[i] != vote_state) || (cp_count[i] != vote_count) ||
                    (cp_data[i] != vote_data);
  end

  // Registered disagreement flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mismatch_q <= 1'b0;
    else      mismatch_q <= |disagree;
  end

`ifdef TMR_SIPO_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count_q;

  // Saturating count of cycles with a detected disagreement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    err_count_q <= '0;
    else if (|disagree && (err_count_q != '1))   err_count_q <= err_count_q + ERR_CNT_W'(1);
  end

  assign err_count = err_count_q;
`endif

  assign out_valid    = (vote_state == HOLD);
  assign busy         = (vote_state == SHIFT);
  assign parallel_out = vote_data;
  assign mismatch     = mismatch_q;

endmodule

// File: tb/tb_tmr_sipo_receiver.sv
// Bench for tmr_sipo_receiver: two instances (LSB-first and MSB-first) share
// stimulus. A directed table, hand sequences for reset and upset scrubbing,
// and a randomized run against a frame-level reference model.
module tb_tmr_sipo_receiver;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst, enable, start, serial_in, out_ready;
  logic v0, v1, b0, b1, m0, m1;
  logic [W-1:0] p0, p1;
`ifdef TMR_SIPO_ERR_CNT_EN
  logic [7:0] e0, e1;
`endif

  always #5 clk = ~clk;

  tmr_sipo_receiver #(.width(W), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .serial_in(serial_in),
    .out_ready(out_ready), .out_valid(v0), .parallel_out(p0), .busy(b0), .mismatch(m0)
`ifdef TMR_SIPO_ERR_CNT_EN
    , .err_count(e0)
`endif
  );

  tmr_sipo_receiver #(.width(W), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .serial_in(serial_in),
    .out_ready(out_ready), .out_valid(v1), .parallel_out(p1), .busy(b1), .mismatch(m1)
`ifdef TMR_SIPO_ERR_CNT_EN
    , .err_count(e1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame phase (0 idle, 1 receiving, 2 word held), bits
  // received so far, and received bits indexed by arrival order.
  int           m_phase = 0;
  int           m_n     = 0;
  logic [W-1:0] m_bits  = '0;
  int           exp_err0 = 0;
  logic [W-1:0] inj_val;

  typedef struct {
    logic [3:0]   in;   // {enable, start, serial_in, out_ready}
    logic [2:0]   ex;   // {out_valid, busy, check_word}
    logic [W-1:0] w0;   // expected word, LSB-first instance
    logic [W-1:0] w1;   // expected word, MSB-first instance
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic [3:0] in, input logic [2:0] ex,
                              input logic [W-1:0] w0, input logic [W-1:0] w1);
    vec_t v;
    v.in = in; v.ex = ex; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  function automatic logic [W-1:0] model_word(input bit msb_first);
    logic [W-1:0] w = '0;
    for (int k = 0; k < W; k++) begin
      if (msb_first) w[W-1-k] = m_bits[k];
      else           w[k]     = m_bits[k];
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic en, input logic st, input logic si, input logic rdy);
    case (m_phase)
      0: if (en && st) begin m_bits[0] = si; m_n = 1; m_phase = 1; end
      1: if (en) begin
           m_bits[m_n] = si;
           m_n++;
           if (m_n == W) m_phase = 2;
         end
      default: begin
        if (rdy && en && st) begin m_bits[0] = si; m_n = 1; m_phase = 1; end
        else if (rdy) m_phase = 0;
      end
    endcase
  endtask

  // Called at a negedge: drive inputs, advance the model, wait through the next posedge.
  task automatic step(input logic en, input logic st, input logic si, input logic rdy);
    enable = en; start = st; serial_in = si; out_ready = rdy;
    model_edge(en, st, si, rdy);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid0"}, 32'(v0), 32'(m_phase == 2));
    check({tag, ".valid1"}, 32'(v1), 32'(m_phase == 2));
    check({tag, ".busy0"},  32'(b0), 32'(m_phase == 1));
    check({tag, ".busy1"},  32'(b1), 32'(m_phase == 1));
    check({tag, ".mism0"},  32'(m0), 32'(0));
    check({tag, ".mism1"},  32'(m1), 32'(0));
    if (m_phase == 2) begin
      check({tag, ".word0"}, 32'(p0), 32'(model_word(1'b0)));
      check({tag, ".word1"}, 32'(p1), 32'(model_word(1'b1)));
    end
`ifdef TMR_SIPO_ERR_CNT_EN
    check({tag, ".err0"}, 32'(e0), 32'(exp_err0));
    check({tag, ".err1"}, 32'(e1), 32'(0));
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, {30'b0, v0, v1}, 32'(0));
    check({tag, ".busy"},  {30'b0, b0, b1}, 32'(0));
    check({tag, ".mism"},  {30'b0, m0, m1}, 32'(0));
    check({tag, ".word0"}, 32'(p0), 32'(0));
    check({tag, ".word1"}, 32'(p1), 32'(0));
`ifdef TMR_SIPO_ERR_CNT_EN
    check({tag, ".err"}, {16'b0, e0, e1}, 32'(0));
`endif
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    m_phase = 0; m_n = 0; m_bits = '0; exp_err0 = 0;
    #1 check_zero(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table, applied straight after reset.
    tbl[0]  = mk(4'b1110, 3'b010, 4'h0, 4'h0);
    tbl[1]  = mk(4'b1000, 3'b010, 4'h0, 4'h0);
    tbl[2]  = mk(4'b1010, 3'b010, 4'h0, 4'h0);
    tbl[3]  = mk(4'b1010, 3'b101, 4'b1101, 4'b1011);  // bits 1,0,1,1
    tbl[4]  = mk(4'b1000, 3'b101, 4'b1101, 4'b1011);
    tbl[5]  = mk(4'b1011, 3'b000, 4'h0, 4'h0);         // accepted -> IDLE
    tbl[6]  = mk(4'b1110, 3'b010, 4'h0, 4'h0);
    tbl[7]  = mk(4'b1000, 3'b010, 4'h0, 4'h0);
    tbl[8]  = mk(4'b1010, 3'b010, 4'h0, 4'h0);
    tbl[9]  = mk(4'b0100, 3'b010, 4'h0, 4'h0);         // stall, start ignored
    tbl[10] = mk(4'b0010, 3'b010, 4'h0, 4'h0);         // stall
    tbl[11] = mk(4'b1010, 3'b101, 4'b1101, 4'b1011);
    tbl[12] = mk(4'b1101, 3'b010, 4'h0, 4'h0);         // back-to-back, bit 0
    tbl[13] = mk(4'b1010, 3'b010, 4'h0, 4'h0);
    tbl[14] = mk(4'b1010, 3'b010, 4'h0, 4'h0);
    tbl[15] = mk(4'b1000, 3'b101, 4'b0110, 4'b0110);  // bits 0,1,1,0
    tbl[16] = mk(4'b1111, 3'b010, 4'h0, 4'h0);         // back-to-back, bit 1
    tbl[17] = mk(4'b1000, 3'b010, 4'h0, 4'h0);
    tbl[18] = mk(4'b1000, 3'b010, 4'h0, 4'h0);
    tbl[19] = mk(4'b1000, 3'b101, 4'b0001, 4'b1000);  // bits 1,0,0,0
    tbl[20] = mk(4'b1110, 3'b101, 4'b0001, 4'b1000);  // start w/o ready: frozen
    tbl[21] = mk(4'b0011, 3'b000, 4'h0, 4'h0);         // ready alone -> IDLE

    rst = 1'b0; enable = 1'b0; start = 1'b0; serial_in = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      check($sformatf("tbl%0d.valid", i), {30'b0, v0, v1}, {30'b0, tbl[i].ex[2], tbl[i].ex[2]});
      check($sformatf("tbl%0d.busy", i),  {30'b0, b0, b1}, {30'b0, tbl[i].ex[1], tbl[i].ex[1]});
      check($sformatf("tbl%0d.mism", i),  {30'b0, m0, m1}, 32'(0));
      if (tbl[i].ex[0]) begin
        check($sformatf("tbl%0d.word0", i), 32'(p0), 32'(tbl[i].w0));
        check($sformatf("tbl%0d.word1", i), 32'(p1), 32'(tbl[i].w1));
      end
    end

    // Word held for 10 cycles with no ready while inputs wiggle.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_model("hold_entry");
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'(i % 2), 1'b0);
      check_model($sformatf("hold%0d", i));
    end

    // Upset in HOLD: copy 0 data bit 0 flipped; one cycle of mismatch, word intact.
    inj_val = dut0.u_copy0.data_q ^ 4'b0001;
    force dut0.u_copy0.data_q = inj_val;
    #1 release dut0.u_copy0.data_q;
    check("seu_hold.word_now", 32'(p0), 32'(model_word(1'b0)));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    exp_err0++;
    check("seu_hold.mism0", 32'(m0), 32'(1));
    check("seu_hold.valid0", 32'(v0), 32'(1));
    check("seu_hold.word0", 32'(p0), 32'(model_word(1'b0)));
    check("seu_hold.copy0", 32'(dut0.u_copy0.data_q), 32'(model_word(1'b0)));
`ifdef TMR_SIPO_ERR_CNT_EN
    check("seu_hold.err0", 32'(e0), 32'(exp_err0));
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_model("seu_hold_after");
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_model("hold_release");

    // Upset during SHIFT: after bits 1,0 the LSB-first copies hold 4'b0100.
    do_reset("rst_pre_seu");
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    inj_val = dut0.u_copy2.data_q ^ 4'b1000;
    force dut0.u_copy2.data_q = inj_val;
    #1 release dut0.u_copy2.data_q;
    check("seu_shift.word_now", 32'(p0), 32'(4'b0100));
    step(1'b0, 1'b0, 1'b1, 1'b0);   // stall while copy 2 is reloaded
    exp_err0++;
    check("seu_shift.mism0", 32'(m0), 32'(1));
    check("seu_shift.mism1", 32'(m1), 32'(0));
    check("seu_shift.busy0", 32'(b0), 32'(1));
    check("seu_shift.word0", 32'(p0), 32'(4'b0100));
    check("seu_shift.copy2", 32'(dut0.u_copy2.data_q), 32'(4'b0100));
`ifdef TMR_SIPO_ERR_CNT_EN
    check("seu_shift.err0", 32'(e0), 32'(exp_err0));
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_model("seu_shift_after");
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_model("seu_shift_word");
    check("seu_shift.word_const", 32'(p0), 32'(4'b1101));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_model("seu_shift_idle");

    // Reset after bit 2 of a frame, then a clean frame bits 0,1,1,1.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    do_reset("rst_mid_frame");
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check_model("rst_mid_idle");
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_model("rst_then_frame");
    check("rst_then_frame.w0", 32'(p0), 32'(4'b1110));
    check("rst_then_frame.w1", 32'(p1), 32'(4'b0111));

    // Reset while holding a word: valid is dropped and nothing reappears.
    do_reset("rst_mid_hold");
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check_model("rst_hold_idle");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      check_model($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
